// File: rtl/dpram_arbiter.sv
// rtl/dpram_arbiter.sv - CPU-priority arbiter for the J1 data dual-port RAM port with a burst DMA master
// Optional stall statistics counter enabled by DPRAM_ARB_STATS_EN.
module dpram_arbiter #(
    parameter int AW  = 8,
    parameter int DW  = 16,
    parameter int BLW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cpu_cs,
    input  logic           cpu_rd,
    input  logic           cpu_wr,
    input  logic [AW-1:0]  cpu_addr,
    input  logic [DW-1:0]  cpu_din,
    output logic [DW-1:0]  cpu_dout,
    input  logic           dma_req,
    input  logic           dma_we,
    input  logic [AW-1:0]  dma_addr,
    input  logic [BLW-1:0] dma_len,
    output logic           dma_gnt,
    output logic           dma_ack,
    input  logic [DW-1:0]  dma_wdata,
    output logic           dma_rvalid,
    output logic [DW-1:0]  dma_rdata,
    output logic           dma_done,
    output logic           ram_cs,
    output logic           ram_rd,
    output logic           ram_wr,
    output logic [AW-1:0]  ram_addr,
    output logic [DW-1:0]  ram_din,
`ifdef DPRAM_ARB_STATS_EN
    output logic [15:0]    stall_cnt,
    input  logic           stats_clr,
`endif
    input  logic [DW-1:0]  ram_dout
);

    typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

    state_t         state, state_nx;
    logic [AW-1:0]  addr_q;
    logic [BLW-1:0] len_q;
    logic [BLW-1:0] cnt;
    logic           we_q;
    logic           rvalid_q;
    logic           cpu_hit;

    assign cpu_hit = cpu_cs & (cpu_rd | cpu_wr);

    // The CPU path is purely combinational and always wins; a DMA beat only fills idle cycles.
    always_comb begin
        state_nx = state;
        dma_gnt  = 1'b0;
        dma_ack  = 1'b0;
        dma_done = 1'b0;
        ram_cs   = 1'b0;
        ram_rd   = 1'b0;
        ram_wr   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (cpu_hit) begin
            ram_cs   = 1'b1;
            ram_rd   = cpu_rd;
            ram_wr   = cpu_wr;
            ram_addr = cpu_addr;
            ram_din  = cpu_din;
        end
        case (state)
            IDLE: begin
                if (dma_req) begin
                    dma_gnt  = 1'b1;
                    state_nx = BURST;
                end
            end
            BURST: begin
                if (!cpu_hit) begin
                    dma_ack  = 1'b1;
                    ram_cs   = 1'b1;
                    ram_wr   = we_q;
                    ram_rd   = !we_q;
                    ram_addr = addr_q;
                    ram_din  = dma_wdata;
                    if (cnt == len_q) begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                dma_done = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // Outputs are forced low while reset is held, independent of the inputs.
        if (!rst) begin
            dma_gnt  = 1'b0;
            dma_ack  = 1'b0;
            dma_done = 1'b0;
            ram_cs   = 1'b0;
            ram_rd   = 1'b0;
            ram_wr   = 1'b0;
            ram_addr = '0;
            ram_din  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            cnt      <= '0;
            we_q     <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            state    <= state_nx;
            rvalid_q <= dma_ack & ~we_q;
            if (dma_gnt) begin
                addr_q <= dma_addr;
                len_q  <= dma_len;
                we_q   <= dma_we;
                cnt    <= '0;
            end else if (dma_ack) begin
                addr_q <= addr_q + AW'(1);
                cnt    <= cnt + BLW'(1);
            end
        end
    end

    assign dma_rvalid = rvalid_q;
    assign dma_rdata  = rvalid_q ? ram_dout : '0;
    assign cpu_dout   = ram_dout;

`ifdef DPRAM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (stats_clr) begin
            stall_cnt <= '0;
        end else if (state == BURST && cpu_hit && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dpram_arbiter.sv
// tb/tb_dpram_arbiter.sv - scoreboard bench for dpram_arbiter
module tb_dpram_arbiter;

    localparam int AW  = 8;
    localparam int DW  = 16;
    localparam int BLW = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] data;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           cpu_cs = 1'b0, cpu_rd = 1'b0, cpu_wr = 1'b0;
    logic [AW-1:0]  cpu_addr = '0;
    logic [DW-1:0]  cpu_din = '0;
    logic [DW-1:0]  cpu_dout;
    logic           dma_req = 1'b0, dma_we = 1'b0;
    logic [AW-1:0]  dma_addr = '0;
    logic [BLW-1:0] dma_len = '0;
    logic           dma_gnt, dma_ack, dma_rvalid, dma_done;
    logic [DW-1:0]  dma_wdata = '0;
    logic [DW-1:0]  dma_rdata;
    logic           ram_cs, ram_rd, ram_wr;
    logic [AW-1:0]  ram_addr;
    logic [DW-1:0]  ram_din;
    logic [DW-1:0]  ram_dout = '0;
`ifdef DPRAM_ARB_STATS_EN
    logic [15:0]    stall_cnt;
    logic           stats_clr = 1'b0;
`endif

    logic [DW-1:0] mem     [0:255];
    logic [DW-1:0] ref_mem [0:255];
    beat_t         exp_beat_q[$];
    logic [DW-1:0] exp_rd_q[$];
    beat_t         mb;
    int            n_chk = 0;
    int            n_pass = 0;
    int            n_rvalid = 0;
    int            clr_at = -1;

    always #5 clk = ~clk;

    dpram_arbiter #(.AW(AW), .DW(DW), .BLW(BLW)) dut (
        .clk(clk), .rst(rst),
        .cpu_cs(cpu_cs), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_len(dma_len),
        .dma_gnt(dma_gnt), .dma_ack(dma_ack), .dma_wdata(dma_wdata),
        .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata), .dma_done(dma_done),
        .ram_cs(ram_cs), .ram_rd(ram_rd), .ram_wr(ram_wr),
        .ram_addr(ram_addr), .ram_din(ram_din),
`ifdef DPRAM_ARB_STATS_EN
        .stall_cnt(stall_cnt), .stats_clr(stats_clr),
`endif
        .ram_dout(ram_dout)
    );

    // RAM model with registered read data
    always @(posedge clk) begin
        if (ram_cs && ram_wr) mem[ram_addr] <= ram_din;
        if (ram_cs && ram_rd) ram_dout <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_outs_zero(input string tag);
        check({tag, "_ctl"}, {25'd0, dma_gnt, dma_ack, dma_rvalid, dma_done, ram_cs, ram_rd, ram_wr}, 32'd0);
        check({tag, "_bus"}, {ram_addr, ram_din}, 32'd0);
        check({tag, "_rdata"}, dma_rdata, 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (dma_rvalid) begin
                n_rvalid++;
                if (exp_rd_q.size() == 0) check("rvalid_unexpected", 1, 0);
                else check("dma_rdata", dma_rdata, exp_rd_q.pop_front());
            end
            if (dma_ack) begin
                if (exp_beat_q.size() == 0) begin
                    check("beat_unexpected", 1, 0);
                end else begin
                    mb = exp_beat_q.pop_front();
                    check("beat_addr", ram_addr, mb.addr);
                    check("beat_wr", ram_wr, mb.we);
                    check("beat_rd", ram_rd, !mb.we);
                    if (mb.we) check("beat_wdata", ram_din, mb.data);
                end
            end
        end
    end

    task automatic run_burst(input logic we, input logic [AW-1:0] a, input logic [BLW-1:0] len,
                             input logic [DW-1:0] dbase, input int st0, input int stn, input int cpu_op,
                             input logic [AW-1:0] caddr, input bit hold, input int exp_cycles);
        int    beat, cyc, w;
        logic  hit;
        beat_t e;
        @(posedge clk); #1;
        dma_req = 1'b1; dma_we = we; dma_addr = a; dma_len = len;
        if (cpu_op == 2) ref_mem[caddr] = 16'hCAFE;
        for (int i = 0; i <= int'(len); i++) begin
            e.addr = a + AW'(i);
            e.we   = we;
            e.data = dbase * 16'(i + 1);
            if (we) ref_mem[e.addr] = e.data;
            else exp_rd_q.push_back(ref_mem[e.addr]);
            exp_beat_q.push_back(e);
        end
        w = 0;
        @(negedge clk);
        while (!dma_gnt && w < 10) begin
            @(negedge clk);
            w++;
        end
        check("gnt_seen", dma_gnt, 1);
        check("gnt_latency", w, 0);
        beat = 0;
        cyc  = 0;
        @(posedge clk); #1;
        while (beat <= int'(len) && cyc < int'(len) + stn + 8) begin
            dma_wdata = dbase * 16'(beat + 1);
            hit = (cyc >= st0) && (cyc < st0 + stn);
            cpu_cs = hit; cpu_rd = hit && cpu_op == 1; cpu_wr = hit && cpu_op == 2;
            cpu_addr = caddr; cpu_din = 16'hCAFE;
`ifdef DPRAM_ARB_STATS_EN
            stats_clr = (cyc == clr_at);
`endif
            @(negedge clk);
            if (hit && cyc == st0) begin
                check("stall_noack", dma_ack, 0);
                check("stall_addr", ram_addr, caddr);
            end
            if (dma_ack) beat++;
            cyc++;
            @(posedge clk); #1;
        end
        cpu_cs = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0;
`ifdef DPRAM_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        if (!hold) dma_req = 1'b0;
        check("beat_cycles", cyc, exp_cycles);
        @(negedge clk);
        check("dma_done", dma_done, 1);
        check("gnt_in_done", dma_gnt, 0);
    endtask

    task automatic drain(input string tag);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_beats_left"}, exp_beat_q.size(), 0);
        check({tag, "_reads_left"}, exp_rd_q.size(), 0);
    endtask

    initial begin
        int rv0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        // reset held with active inputs: outputs must stay low
        dma_req = 1'b1; cpu_cs = 1'b1; cpu_wr = 1'b1; cpu_addr = 8'h33; cpu_din = 16'h5A5A;
        #12;
        check_outs_zero("reset");
        dma_req = 1'b0; cpu_cs = 1'b0; cpu_wr = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_no_gnt", dma_gnt, 0);
        end

        // CPU write then read
        @(posedge clk); #1;
        cpu_cs = 1'b1; cpu_wr = 1'b1; cpu_addr = 8'h10; cpu_din = 16'hBEEF;
        @(negedge clk);
        check("cpu_wr_same_cycle", {ram_cs, ram_wr, ram_addr, ram_din}, {2'b11, 8'h10, 16'hBEEF});
        ref_mem[8'h10] = 16'hBEEF;
        @(posedge clk); #1;
        cpu_wr = 1'b0; cpu_rd = 1'b1;
        @(negedge clk);
        check("cpu_rd_same_cycle", {ram_cs, ram_rd, ram_addr}, {2'b11, 8'h10});
        @(posedge clk); #1;
        cpu_cs = 1'b0; cpu_rd = 1'b0;
        @(negedge clk);
        check("cpu_dout", cpu_dout, 16'hBEEF);

        // write burst wrapping past 0xFF
        run_burst(1'b1, 8'hFE, 4'd3, 16'h1111, -1, 0, 0, 8'h00, 1'b0, 4);
        drain("wr_wrap");

        // read burst preempted by a CPU read on the second beat cycle
        rv0 = n_rvalid;
        run_burst(1'b0, 8'h00, 4'd2, 16'h0000, 1, 1, 1, 8'h55, 1'b0, 4);
        drain("preempt");
        check("preempt_rvalid_count", n_rvalid - rv0, 3);

        // CPU write and DMA write to the same address: DMA lands after the CPU
        run_burst(1'b1, 8'h30, 4'd1, 16'h0A0A, 0, 1, 2, 8'h30, 1'b0, 3);
        drain("collide");
        run_burst(1'b0, 8'h30, 4'd1, 16'h0000, -1, 0, 0, 8'h00, 1'b0, 2);
        drain("collide_rb");

        // back-to-back with request held across dma_done
        run_burst(1'b1, 8'h20, 4'd1, 16'h0123, -1, 0, 0, 8'h00, 1'b1, 2);
        run_burst(1'b0, 8'h20, 4'd1, 16'h0000, -1, 0, 0, 8'h00, 1'b0, 2);
        drain("b2b");

        // reset in the middle of a burst
        @(posedge clk); #1;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'h40; dma_len = 4'd7; dma_wdata = 16'h7777;
        for (int i = 0; i < 8; i++) exp_beat_q.push_back('{addr: 8'h40 + 8'(i), we: 1'b1, data: 16'h7777});
        @(negedge clk);
        check("mid_gnt", dma_gnt, 1);
        @(posedge clk); #1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_outs_zero("mid_reset");
        exp_beat_q.delete();
        exp_rd_q.delete();
        dma_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("abort_quiet", {dma_done, ram_cs, dma_ack}, 3'b000);
        end

`ifdef DPRAM_ARB_STATS_EN
        check("stats_reset", stall_cnt, 0);
        run_burst(1'b1, 8'h60, 4'd0, 16'h0101, 0, 5, 1, 8'h61, 1'b0, 6);
        check("stats_five", stall_cnt, 5);
        clr_at = 2;
        run_burst(1'b1, 8'h62, 4'd0, 16'h0202, 0, 3, 1, 8'h61, 1'b0, 4);
        clr_at = -1;
        check("stats_clr_wins", stall_cnt, 0);
        run_burst(1'b1, 8'h63, 4'd0, 16'h0303, 0, 65540, 1, 8'h61, 1'b0, 65541);
        check("stats_saturate", stall_cnt, 16'hFFFF);
        drain("stats");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
